sync_filt_3v: RTL and testbench



---
 rtl/sync_filt_3v_pkg.sv | 9 +
 rtl/sync_filt_3v_ch.sv | 41 ++++
 rtl/sync_filt_3v.sv | 35 +++
 tb/tb_sync_filt_3v.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/sync_filt_3v_pkg.sv
// sync_filt_3v_pkg: parameter limits and counter sizing shared by the sync_filt_3v cells
package sync_filt_3v_pkg;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILT_LEN_MAX = 255;
  function automatic int cnt_width(input int filt_len);
    return $clog2(filt_len + 1);
  endfunction
endpackage

// File: rtl/sync_filt_3v_ch.sv
// sync_filt_3v_ch: one channel -- synchroniser a->s, stable-count filter to q, qr/qf edge pulses, sticky ev cleared by clr
module sync_filt_3v_ch
  import sync_filt_3v_pkg::*;
#(
  parameter int   STAGES   = 2,
  parameter int   FILT_LEN = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic clr,
  output logic q,
  output logic qr,
  output logic qf,
  output logic ev
);
  localparam int CW = cnt_width(FILT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);
  logic [STAGES-1:0] s;
  logic [CW-1:0] cnt;
  logic sync_out, flip;
  assign sync_out = s[STAGES-1];
  assign flip = (sync_out != q) && (cnt == CNT_LAST);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s   <= {STAGES{RST_VAL}};
      cnt <= '0;
      q   <= RST_VAL;
      qr  <= 1'b0;
      qf  <= 1'b0;
      ev  <= 1'b0;
    end else begin
      s   <= {s[STAGES-2:0], a};
      cnt <= (sync_out == q || flip) ? '0 : cnt + CW'(1);
      q   <= q ^ flip;
      qr  <= flip & sync_out;
      qf  <= flip & ~sync_out;
      ev  <= flip | (ev & ~clr);
    end
endmodule

// File: rtl/sync_filt_3v.sv
// sync_filt_3v: WIDTH-channel pad conditioner; C clk, R async reset, A raw in, CLR ev clear mask, Q filtered level, QR/QF edge pulses, EV sticky event
module sync_filt_3v
  import sync_filt_3v_pkg::*;
#(
  parameter int   WIDTH    = 1,
  parameter int   STAGES   = 2,
  parameter int   FILT_LEN = 4,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QR,
  output logic [WIDTH-1:0] QF,
  output logic [WIDTH-1:0] EV
);
  if (WIDTH < 1 || STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
      FILT_LEN < 1 || FILT_LEN > FILT_LEN_MAX) begin : g_bad_param
    $fatal(1, "sync_filt_3v: parameter out of legal range");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filt_3v_ch #(.STAGES(STAGES), .FILT_LEN(FILT_LEN), .RST_VAL(RST_VAL)) u_ch (
      .clk(C),
      .rst(R),
      .a(A[i]),
      .clr(CLR[i]),
      .q(Q[i]),
      .qr(QR[i]),
      .qf(QF[i]),
      .ev(EV[i])
    );
  end
endmodule

// File: tb/tb_sync_filt_3v.sv
// tb_sync_filt_3v: directed stimulus on three configurations, window-based reference model, per-cycle compare plus literal pins
module tb_sync_filt_3v;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] a_a, clr_a, q_a, qr_a, qf_a, ev_a;
  logic       a_b, clr_b, q_b, qr_b, qf_b, ev_b;
  logic [3:0] a_c, clr_c, q_c, qr_c, qf_c, ev_c;
  sync_filt_3v #(.WIDTH(2)) u_a (
    .C(clk), .R(rst), .A(a_a), .CLR(clr_a), .Q(q_a), .QR(qr_a), .QF(qf_a), .EV(ev_a)
  );
  sync_filt_3v #(.WIDTH(1), .STAGES(3), .FILT_LEN(1)) u_b (
    .C(clk), .R(rst), .A(a_b), .CLR(clr_b), .Q(q_b), .QR(qr_b), .QF(qf_b), .EV(ev_b)
  );
  sync_filt_3v #(.WIDTH(4), .RST_VAL(1'b1)) u_c (
    .C(clk), .R(rst), .A(a_c), .CLR(clr_c), .Q(q_c), .QR(qr_c), .QF(qf_c), .EV(ev_c)
  );
  localparam int   ST[3] = '{2, 3, 2};
  localparam int   FL[3] = '{4, 1, 4};
  localparam logic RV[3] = '{1'b0, 1'b0, 1'b1};
  logic [3:0] ain[3], cin[3], dq[3], dr[3], df[3], de[3];
  assign ain[0] = {2'b0, a_a};
  assign ain[1] = {3'b0, a_b};
  assign ain[2] = a_c;
  assign cin[0] = {2'b0, clr_a};
  assign cin[1] = {3'b0, clr_b};
  assign cin[2] = clr_c;
  assign dq[0] = {2'b0, q_a};
  assign dq[1] = {3'b0, q_b};
  assign dq[2] = q_c;
  assign dr[0] = {2'b0, qr_a};
  assign dr[1] = {3'b0, qr_b};
  assign dr[2] = qr_c;
  assign df[0] = {2'b0, qf_a};
  assign df[1] = {3'b0, qf_b};
  assign df[2] = qf_c;
  assign de[0] = {2'b0, ev_a};
  assign de[1] = {3'b0, ev_b};
  assign de[2] = ev_c;
  // Reference model: h holds raw A samples (bit 0 = latest edge). The level reaching
  // the filter at an edge is the sample taken STAGES edges earlier; Q flips when the
  // last FILT_LEN such levels all disagree with the current Q.
  logic [15:0] h[3][4];
  logic [3:0]  mq[3], mr[3], mf[3], me[3];
  function automatic logic flips(input logic [15:0] hv, input logic qv, input int st, input int fl);
    for (int j = 0; j < fl; j++)
      if (hv[st - 1 + j] == qv) return 1'b0;
    return 1'b1;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < 4; i++) h[k][i] <= {16{RV[k]}};
        mq[k] <= {4{RV[k]}};
        mr[k] <= '0;
        mf[k] <= '0;
        me[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < 4; i++) begin
          mq[k][i] <= mq[k][i] ^ flips(h[k][i], mq[k][i], ST[k], FL[k]);
          mr[k][i] <= flips(h[k][i], mq[k][i], ST[k], FL[k]) & ~mq[k][i];
          mf[k][i] <= flips(h[k][i], mq[k][i], ST[k], FL[k]) & mq[k][i];
          me[k][i] <= flips(h[k][i], mq[k][i], ST[k], FL[k]) | (me[k][i] & ~cin[k][i]);
          h[k][i]  <= {h[k][i][14:0], ain[k][i]};
        end
    end
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input int k, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst %0d at %0t: got %b expected %b", nm, k, $time, got, exp);
    end
  endtask
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      chk("q", k, dq[k], mq[k]);
      chk("qr", k, dr[k], mr[k]);
      chk("qf", k, df[k], mf[k]);
      chk("ev", k, de[k], me[k]);
    end
  initial begin
    a_a = '0; clr_a = '0; a_b = 1'b0; clr_b = 1'b0; a_c = 4'hF; clr_c = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_q_a", 0, 4'(q_a), 4'b0000);
    chk("rst_q_c", 2, q_c, 4'b1111);
    a_a = 2'b11;
    a_c = 4'b1010;
    repeat (3) @(negedge clk);
    a_a[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("lat_pre_q", 0, 4'(q_a), 4'b0000);
    chk("c_pre_q", 2, q_c, 4'b1111);
    @(negedge clk);
    chk("lat_q", 0, 4'(q_a), 4'b0001);
    chk("lat_qr", 0, 4'(qr_a), 4'b0001);
    chk("lat_qf", 0, 4'(qf_a), 4'b0000);
    chk("glitch_ev", 0, 4'(ev_a), 4'b0001);
    chk("model_pin_q", 0, mq[0], 4'b0001);
    chk("c_q", 2, q_c, 4'b1010);
    chk("c_qf", 2, qf_c, 4'b0101);
    chk("c_qr", 2, qr_c, 4'b0000);
    chk("model_pin_qf", 2, mf[2], 4'b0101);
    @(negedge clk);
    chk("lat_qr_end", 0, 4'(qr_a), 4'b0000);
    chk("c_qf_end", 2, qf_c, 4'b0000);
    a_a[1] = 1'b1;
    repeat (4) @(negedge clk);
    a_a[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("four_q", 0, 4'(q_a), 4'b0011);
    repeat (6) @(negedge clk);
    clr_a = 2'b01;
    @(negedge clk);
    clr_a = 2'b00;
    chk("ev_clr", 0, 4'(ev_a[0]), 4'b0000);
    a_a[0] = 1'b0;
    repeat (5) @(negedge clk);
    clr_a = 2'b01;
    @(negedge clk);
    chk("race_ev", 0, 4'(ev_a[0]), 4'b0001);
    chk("race_qf", 0, 4'(qf_a[0]), 4'b0001);
    @(negedge clk);
    clr_a = 2'b00;
    chk("race_ev_next", 0, 4'(ev_a[0]), 4'b0000);
    for (int c = 0; c < 24; c++) begin
      a_b = ((c / 2) % 2) == 0;
      @(negedge clk);
      if (c == 2) chk("b_pre_q", 1, 4'(q_b), 4'b0000);
      if (c == 3) chk("b_qr", 1, {3'b0, qr_b}, 4'b0001);
      if (c == 4) chk("b_qr_end", 1, {2'b0, qr_b, qf_b}, 4'b0000);
      if (c == 5) chk("b_qf", 1, {2'b0, q_b, qf_b}, 4'b0001);
    end
    a_a = 2'b11;
    repeat (10) @(negedge clk);
    chk("pre_rst_ev", 0, 4'(ev_a), 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("async_q", 0, 4'(q_a), 4'b0000);
    chk("async_ev", 0, 4'(ev_a), 4'b0000);
    chk("async_pulse", 0, {qr_a, qf_a}, 4'b0000);
    chk("async_q_c", 2, q_c, 4'b1111);
    a_a = 2'b00;
    a_b = 1'b0;
    a_c = 4'hF;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_ev", 0, 4'(ev_a), 4'b0000);
    chk("post_rst_ev_c", 2, ev_c, 4'b0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
